mul_seq_radix: RTL and testbench



---
 rtl/mul_seq_radix_if.sv | 21 ++
 rtl/mul_seq_radix.sv | 92 +++++++++
 tb/tb_mul_seq_radix.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mul_seq_radix_if.sv
// Operand/result bundle for mul_seq_radix.
// The SIGNED line exists only when MUL_SEQ_SIGNED_EN is defined.
interface mul_seq_radix_if #(
  parameter int LEN = 16
);
  logic                 START;
  logic [LEN-1:0]       A;
  logic [LEN-1:0]       B;
  logic                 BUSY;
  logic                 DONE;
  logic [2*LEN-1:0]     Y;
`ifdef MUL_SEQ_SIGNED_EN
  logic                 SIGNED;

  modport master (output START, A, B, SIGNED, input BUSY, DONE, Y);
  modport slave  (input START, A, B, SIGNED, output BUSY, DONE, Y);
`else
  modport master (output START, A, B, input BUSY, DONE, Y);
  modport slave  (input START, A, B, output BUSY, DONE, Y);
`endif
endinterface

// File: rtl/mul_seq_radix.sv
// Digit-serial LEN x LEN -> 2*LEN multiplier, DIGIT multiplier bits per RUN cycle.
// Optional two's-complement mode is enabled with MUL_SEQ_SIGNED_EN (adds SIGNED).
module mul_seq_radix #(
  parameter int LEN   = 16,
  parameter int DIGIT = 4
) (
  input  logic           CLK,
  input  logic           RST,
  mul_seq_radix_if.slave bus
);
  localparam int W = 2 * LEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [LEN-1:0] ONE_L = LEN'(1);
  localparam logic [W-1:0]   ONE_W = W'(1);

  logic [1:0]     state;
  logic [W-1:0]   mcand;
  logic [LEN-1:0] mplier;
  logic [W-1:0]   acc;
  logic           neg;
  logic [W-1:0]   y_q;

  logic [LEN-1:0] a_mag;
  logic [LEN-1:0] b_mag;
  logic           neg_in;
  logic [W-1:0]   digit_w;
  logic [W-1:0]   partial;
  logic [W-1:0]   y_fin;

  // Operand magnitudes and sign; the most negative value maps to 2^(LEN-1).
  always_comb begin
    a_mag  = bus.A;
    b_mag  = bus.B;
    neg_in = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
    if (bus.SIGNED) begin
      a_mag  = bus.A[LEN-1] ? (~bus.A + ONE_L) : bus.A;
      b_mag  = bus.B[LEN-1] ? (~bus.B + ONE_L) : bus.B;
      neg_in = bus.A[LEN-1] ^ bus.B[LEN-1];
    end
`endif
  end

  always_comb begin
    digit_w = W'(mplier[DIGIT-1:0]);
    partial = mcand * digit_w;
    y_fin   = neg ? (~acc + ONE_W) : acc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      y_q    <= '0;
    end else if (bus.START) begin
      mcand  <= W'(a_mag);
      mplier <= b_mag;
      acc    <= '0;
      neg    <= neg_in;
      state  <= RUN;
    end else begin
      case (state)
        RUN: begin
          // Stop as soon as no nonzero multiplier digits (or multiplicand bits) remain.
          if (mcand == '0 || mplier == '0) begin
            y_q   <= y_fin;
            state <= FIN;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << DIGIT;
            mplier <= mplier >> DIGIT;
          end
        end
        FIN:     state <= FIN;
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY = (state == RUN);
  assign bus.DONE = (state == FIN);
  assign bus.Y    = y_q;

endmodule

// File: tb/tb_mul_seq_radix.sv
// Scoreboard bench for mul_seq_radix (LEN=16, DIGIT=4) with directed vectors.
module tb_mul_seq_radix;
  logic CLK;
  logic RST;

  mul_seq_radix_if #(.LEN(16)) bus ();

  mul_seq_radix #(.LEN(16), .DIGIT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] y;
    int unsigned lat;
    int unsigned s;
    int unsigned id;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic        done_q = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // Monitor: pop expected result on every DONE rise.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.DONE && !done_q) begin
      chk(sb.size() != 0, "done_expected", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(bus.Y == e.y, $sformatf("y_op%0d", e.id), bus.Y, e.y);
        chk((cyc - e.s - 1) == e.lat, $sformatf("lat_op%0d", e.id), 32'(cyc - e.s - 1), 32'(e.lat));
      end
    end
    done_q = bus.DONE;
  end

  // Called at a negedge; returns at the negedge following the sampling edge E0.
  task automatic start_raw(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
`ifdef MUL_SEQ_SIGNED_EN
    bus.SIGNED = sgn;
`else
    if (sgn) $display("signed request ignored in unsigned build");
`endif
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic start_op(input int unsigned id, input logic [15:0] a, input logic [15:0] b,
                          input bit sgn, input logic [31:0] y, input int unsigned lat);
    exp_t e;
    e.y = y; e.lat = lat; e.s = cyc; e.id = id;
    sb.push_back(e);
    start_raw(a, b, sgn);
  endtask

  task automatic wait_empty();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, "timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef MUL_SEQ_SIGNED_EN
    bus.SIGNED = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    chk(bus.Y == 32'h0, "rst_y", bus.Y, 32'h0);
    chk(bus.BUSY == 1'b0, "rst_busy", 32'(bus.BUSY), 32'h0);
    chk(bus.DONE == 1'b0, "rst_done", 32'(bus.DONE), 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    start_op(1, 16'd3, 16'd5, 1'b0, 32'h0000000F, 2);
    chk(bus.BUSY == 1'b1, "busy_after_e0", 32'(bus.BUSY), 32'h1);
    wait_empty();

    // Worst case: BUSY for E0..E4, Y holds the previous product meanwhile.
    start_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 5);
    for (int i = 0; i < 5; i++) begin
      chk(bus.BUSY == 1'b1, $sformatf("busy_run%0d", i), 32'(bus.BUSY), 32'h1);
      if (i > 0) chk(bus.Y == 32'h0000000F, $sformatf("y_hold%0d", i), bus.Y, 32'h0000000F);
      @(negedge CLK);
    end
    wait_empty();

    start_op(3, 16'h04D2, 16'h0000, 1'b0, 32'h0, 1);
    wait_empty();
    start_op(4, 16'h0000, 16'hFFFF, 1'b0, 32'h0, 1);
    wait_empty();

    // Abort: second START at E2 replaces the first operation.
    start_raw(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge CLK);
    start_op(5, 16'd2, 16'd7, 1'b0, 32'd14, 2);
    wait_empty();

    // Reset at E2 of a long run.
    start_raw(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk(bus.Y == 32'h0, "midrst_y", bus.Y, 32'h0);
    chk(bus.BUSY == 1'b0, "midrst_busy", 32'(bus.BUSY), 32'h0);
    chk(bus.DONE == 1'b0, "midrst_done", 32'(bus.DONE), 32'h0);
    repeat (3) @(negedge CLK);
    chk(bus.BUSY == 1'b0 && bus.DONE == 1'b0, "idle_hold", {30'h0, bus.BUSY, bus.DONE}, 32'h0);

    start_op(6, 16'h1234, 16'h0010, 1'b0, 32'h00012340, 3);
    wait_empty();
    start_op(7, 16'hABCD, 16'h1000, 1'b0, 32'h0ABCD000, 5);
    wait_empty();

`ifdef MUL_SEQ_SIGNED_EN
    start_op(8, 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1, 2);
    wait_empty();
    start_op(9, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 5);
    wait_empty();
    start_op(10, 16'hFFFD, 16'd5, 1'b0, 32'h0004FFF1, 2);
    wait_empty();
`endif

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
